// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    COUNT_UP = 2'b00,
    COUNT_DN = 2'b01,
    SCAN     = 2'b10,
    FILL     = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int unsigned PWM_W     = 8;
  localparam int unsigned MAX_LED_W = 64;

  // Start pattern of a mode, right-aligned in MAX_LED_W bits; callers truncate to w.
  function automatic logic [MAX_LED_W-1:0] start_value(input mode_t m, input int unsigned w);
    logic [MAX_LED_W-1:0] v;
    v = '0;
    case (m)
      COUNT_DN: begin
        v = '1;
        v = v >> (MAX_LED_W - w);
      end
      SCAN:    v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles; clr restarts the period.
module step_prescaler #(
  parameter int unsigned DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRESC_W-1:0] presc;
  logic               at_end;

  assign at_end = (presc == PRESC_W'(DIV - 1));
  assign tick   = en & ~clr & at_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= at_end ? '0 : presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver (count up/down, scanner, Johnson fill) at a prescaled step rate.
// Optional PWM brightness stage enabled by defining LED_PATTERN_PWM_EN.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned STEP_DIV = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] duty,
  output logic [LED_W-1:0] leds,
  output logic             step
);

  logic [LED_W-1:0] pat;
  logic [LED_W-1:0] pat_nxt;
  dir_t             dir;
  dir_t             dir_nxt;
  mode_t            mode_q;
  mode_t            mode_in;
  logic             step_q;
  logic             step_nxt;
  logic             chg;
  logic             tick;

  assign mode_in = mode_t'(mode);
  assign chg     = (mode_in != mode_q);

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (chg),
    .tick (tick)
  );

  // Pattern registers; mode_q tracks the input every cycle so a change is seen for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat    <= '0;
      dir    <= DIR_LEFT;
      mode_q <= COUNT_UP;
      step_q <= 1'b0;
    end else begin
      pat    <= pat_nxt;
      dir    <= dir_nxt;
      mode_q <= mode_in;
      step_q <= step_nxt;
    end
  end

  // A mode change wins over a coincident tick and discards it.
  always_comb begin
    pat_nxt  = pat;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    if (chg) begin
      pat_nxt = LED_W'(start_value(mode_in, LED_W));
      dir_nxt = DIR_LEFT;
    end else if (tick) begin
      step_nxt = 1'b1;
      case (mode_q)
        COUNT_UP: pat_nxt = pat + LED_W'(1);
        COUNT_DN: pat_nxt = pat - LED_W'(1);
        SCAN: begin
          // Flip as the end bit is reached so each end is shown for a single step.
          if (dir == DIR_LEFT) begin
            pat_nxt = pat << 1;
            if (pat[LED_W-2]) dir_nxt = DIR_RIGHT;
          end else begin
            pat_nxt = pat >> 1;
            if (pat[1]) dir_nxt = DIR_LEFT;
          end
        end
        FILL:    pat_nxt = {pat[LED_W-2:0], ~pat[LED_W-1]};
        default: pat_nxt = pat;
      endcase
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;
  logic [LED_W-1:0] leds_q;
  logic             step_d;

  assign pwm_on = (pwm_cnt < duty);

  // Brightness gate adds a register stage; step is delayed to stay aligned with leds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt <= '0;
      leds_q  <= '0;
      step_d  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds_q  <= pat & {LED_W{pwm_on}};
      step_d  <= step_q;
    end
  end

  assign leds = leds_q;
  assign step = step_d;
`else
  logic unused_duty;
  assign unused_duty = ^duty;

  assign leds = pat;
  assign step = step_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (LED_W=4, STEP_DIV=4) against a step-index reference model.
module tb_led_pattern_gen;

  localparam int unsigned LED_W    = 4;
  localparam int unsigned STEP_DIV = 4;
  localparam int          NPAT     = 1 << LED_W;
  localparam int          FULL     = NPAT - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [7:0]       duty;
  logic [LED_W-1:0] leds;
  logic             step;

  int tests = 0;
  int fails = 0;

  // Reference model: active mode, number of steps taken since (re)start, cycles into current period.
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_step = 1'b0;
  int m_pwm  = 0;
  int o_leds = 0;
  bit o_step = 1'b0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .LED_W    (LED_W),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .duty (duty),
    .leds (leds),
    .step (step)
  );

  // Pattern shown after k steps of a mode, from closed-form sequences.
  function automatic int pattern_of(input int md, input int k);
    int p;
    case (md)
      0: return k % NPAT;
      1: return FULL - (k % NPAT);
      2: begin
        p = k % (2 * (LED_W - 1));
        return (p <= LED_W - 1) ? (1 << p) : (1 << (2 * (LED_W - 1) - p));
      end
      default: begin
        p = k % (2 * LED_W);
        return (p <= LED_W) ? ((1 << p) - 1) : (FULL & ~((1 << (p - LED_W)) - 1));
      end
    endcase
  endfunction

  task automatic model_edge();
    int pat_before;
    bit step_before;
    pat_before  = pattern_of(m_mode, m_k);
    step_before = m_step;
    if (!rst) begin
      m_mode = 0; m_k = 0; m_cnt = 0; m_step = 1'b0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_k = 0; m_cnt = 0; m_step = 1'b0;
    end else if (en) begin
      if (m_cnt == STEP_DIV - 1) begin
        m_cnt = 0; m_k++; m_step = 1'b1;
      end else begin
        m_cnt++; m_step = 1'b0;
      end
    end else begin
      m_step = 1'b0;
    end
`ifdef LED_PATTERN_PWM_EN
    if (!rst) begin
      o_leds = 0; o_step = 1'b0; m_pwm = 0;
    end else begin
      o_leds = (m_pwm < int'(duty)) ? pat_before : 0;
      o_step = step_before;
      m_pwm  = (m_pwm + 1) % 256;
    end
`else
    o_leds = pattern_of(m_mode, m_k);
    o_step = m_step;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("leds", 32'(leds), 32'(o_leds));
      check("step", 32'(step), 32'(o_step));
    end
  endtask

  initial begin
    int  r;
    bit  found;
    int  on_cnt;
    rst  = 1'b0;
    en   = 1'b1;
    mode = 2'b00;
    duty = 8'd64;

    // Reset state
    cyc(2);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_step", 32'(step), 32'h0);

    // Count up through a full wrap
    rst = 1'b1;
    cyc(70);

    // Switch to scan mid-count
    mode = 2'b10;
    cyc(1);
`ifndef LED_PATTERN_PWM_EN
    check("scan_start_leds", 32'(leds), 32'h1);
    check("scan_start_step", 32'(step), 32'h0);
`endif
    cyc(32);

    // Johnson fill
    mode = 2'b11;
    cyc(40);

    // Count down from reset
    rst  = 1'b0;
    mode = 2'b01;
    cyc(1);
    rst = 1'b1;
    cyc(1);
`ifndef LED_PATTERN_PWM_EN
    check("dn_start_leds", 32'(leds), 32'hF);
`endif
    cyc(12);

    // Freeze mid-period
    cyc(2);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(12);

    // Mode change on a tick cycle
    found = 1'b0;
    for (int i = 0; i < 2 * STEP_DIV && !found; i++) begin
      if (m_cnt == STEP_DIV - 1) found = 1'b1;
      else cyc(1);
    end
    check("tick_align_found", 32'(found), 32'h1);
    mode = 2'b11;
    cyc(1);
`ifndef LED_PATTERN_PWM_EN
    check("chg_on_tick_leds", 32'(leds), 32'h0);
    check("chg_on_tick_step", 32'(step), 32'h0);
`endif
    cyc(9);

    // Reset mid-scan
    mode = 2'b10;
    cyc(9);
    rst = 1'b0;
    cyc(1);
    check("midscan_rst_leds", 32'(leds), 32'h0);
    check("midscan_rst_step", 32'(step), 32'h0);
    rst = 1'b1;
    cyc(10);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      r    = int'($urandom_range(0, 99));
      en   = (r < 85);
      rst  = (r != 0);
      if (r >= 94) mode = 2'($urandom_range(0, 3));
      duty = 8'($urandom_range(0, 255));
      cyc(1);
    end
    rst = 1'b1;

`ifdef LED_PATTERN_PWM_EN
    // Held 1111 pattern under PWM duty 64, then duty 0
    en   = 1'b0;
    mode = 2'b00;
    cyc(1);
    mode = 2'b01;
    duty = 8'd64;
    cyc(4);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (leds == 4'hF) on_cnt++;
    end
    check("pwm_duty64_on", 32'(on_cnt), 32'd64);
    duty = 8'd0;
    cyc(2);
    on_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (leds != 4'h0) on_cnt++;
    end
    check("pwm_duty0_on", 32'(on_cnt), 32'd0);
    en = 1'b1;
    cyc(20);
`else
    on_cnt = 0;
    duty   = 8'd0;
    cyc(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
